// File: rtl/isla_delay_calib.sv
// Per-lane IDELAY calibration: sweeps every tap of each lane against a fixed ADC test
// pattern, then loads the centre of the widest error-free tap window.
module isla_delay_calib #(
    parameter int                         NUM_LANES       = 8,
    parameter int                         TAP_BITS        = 5,
    parameter logic [2*NUM_LANES-1:0]     PATTERN         = 16'hA5C3,
    parameter int                         SAMPLES_PER_TAP = 256,
    parameter int                         LOAD_HOLD       = 8,
    parameter int                         SETTLE          = 32,
    parameter int                         MIN_EYE         = 3
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic                            start_i,
    input  logic [2*NUM_LANES-1:0]          adc_data_i,
    input  logic                            delay_rdy_i,
    output logic [TAP_BITS-1:0]             delay_reg_o,
    output logic [NUM_LANES-1:0]            delay_select_o,
    output logic                            delay_load_o,
    output logic                            busy_o,
    output logic                            done_o,
    output logic [NUM_LANES-1:0]            fail_o,
    output logic [NUM_LANES*TAP_BITS-1:0]   lane_tap_o
);
    localparam int CNT_MAX = (SAMPLES_PER_TAP > SETTLE)
        ? ((SAMPLES_PER_TAP > LOAD_HOLD) ? SAMPLES_PER_TAP : LOAD_HOLD)
        : ((SETTLE > LOAD_HOLD) ? SETTLE : LOAD_HOLD);
    localparam int CNT_W  = $clog2(CNT_MAX + 1);
    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int LEN_W  = TAP_BITS + 1;
    localparam logic [TAP_BITS-1:0] LAST_TAP  = '1;
    localparam logic [LANE_W-1:0]   LAST_LANE = LANE_W'(NUM_LANES - 1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_WAIT_RDY, ST_SET_TAP, ST_SETTLE, ST_SAMPLE,
        ST_RECORD, ST_APPLY, ST_APPLY_SETTLE, ST_DONE
    } state_t;

    state_t                        state_q, state_d;
    logic [LANE_W-1:0]             lane_q, lane_d;
    logic [TAP_BITS-1:0]           tap_q, tap_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic                          bad_q, bad_d;
    logic [TAP_BITS-1:0]           cur_start_q, cur_start_d, best_start_q, best_start_d;
    logic [LEN_W-1:0]              cur_len_q, cur_len_d, best_len_q, best_len_d;
    logic [TAP_BITS-1:0]           centre_q, centre_d;
    logic                          lane_fail_q, lane_fail_d;
    logic [TAP_BITS-1:0]           delay_reg_q, delay_reg_d;
    logic [NUM_LANES-1:0]          delay_select_q, delay_select_d;
    logic                          delay_load_q, delay_load_d;
    logic                          busy_q, busy_d, done_q, done_d;
    logic [NUM_LANES-1:0]          fail_q, fail_d;
    logic [NUM_LANES*TAP_BITS-1:0] lane_tap_q, lane_tap_d;

    // Run tracking for the tap just sampled: extend or close the current run.
    logic                last_tap, close_run, abort;
    logic [LEN_W-1:0]    run_len, win_len;
    logic [TAP_BITS-1:0] run_start, win_start, centre_calc;

    assign last_tap = (tap_q == LAST_TAP);
    assign abort    = !delay_rdy_i &&
                      (state_q inside {ST_SET_TAP, ST_SETTLE, ST_SAMPLE, ST_RECORD,
                                       ST_APPLY, ST_APPLY_SETTLE});

    always_comb begin
        run_len   = cur_len_q;
        run_start = cur_start_q;
        win_len   = best_len_q;
        win_start = best_start_q;
        if (!bad_q) begin
            if (cur_len_q == '0) run_start = tap_q;
            run_len = cur_len_q + LEN_W'(1);
        end
        close_run = bad_q || last_tap;
        if (close_run && (run_len > win_len)) begin
            win_len   = run_len;
            win_start = run_start;
        end
        if (close_run) run_len = '0;
        centre_calc = (win_len >= LEN_W'(MIN_EYE))
                    ? win_start + TAP_BITS'((win_len - LEN_W'(1)) >> 1) : '0;
    end

    always_comb begin
        state_d        = state_q;
        lane_d         = lane_q;
        tap_d          = tap_q;
        cnt_d          = cnt_q;
        bad_d          = bad_q;
        cur_start_d    = cur_start_q;
        cur_len_d      = cur_len_q;
        best_start_d   = best_start_q;
        best_len_d     = best_len_q;
        centre_d       = centre_q;
        lane_fail_d    = lane_fail_q;
        delay_reg_d    = delay_reg_q;
        delay_select_d = delay_select_q;
        delay_load_d   = delay_load_q;
        busy_d         = busy_q;
        done_d         = done_q;
        fail_d         = fail_q;
        lane_tap_d     = lane_tap_q;
        if (abort) begin
            // Lane restarts from tap 0; lanes already finished keep their results.
            state_d      = ST_WAIT_RDY;
            delay_load_d = 1'b0;
            cnt_d        = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        state_d    = ST_WAIT_RDY;
                        busy_d     = 1'b1;
                        done_d     = 1'b0;
                        fail_d     = '0;
                        lane_tap_d = '0;
                        lane_d     = '0;
                        tap_d      = '0;
                    end
                end
                ST_WAIT_RDY: begin
                    cur_start_d  = '0;
                    cur_len_d    = '0;
                    best_start_d = '0;
                    best_len_d   = '0;
                    if (delay_rdy_i) begin
                        state_d        = ST_SET_TAP;
                        tap_d          = '0;
                        cnt_d          = '0;
                        delay_reg_d    = '0;
                        delay_select_d = NUM_LANES'(1) << lane_q;
                        delay_load_d   = 1'b1;
                    end
                end
                ST_SET_TAP, ST_APPLY: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(LOAD_HOLD - 1)) begin
                        cnt_d        = '0;
                        delay_load_d = 1'b0;
                        state_d      = (state_q == ST_SET_TAP) ? ST_SETTLE : ST_APPLY_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(SETTLE - 1)) begin
                        cnt_d   = '0;
                        bad_d   = 1'b0;
                        state_d = ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    bad_d = bad_q | (adc_data_i[2*lane_q +: 2] != PATTERN[2*lane_q +: 2]);
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(SAMPLES_PER_TAP - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_RECORD;
                    end
                end
                ST_RECORD: begin
                    cur_start_d  = run_start;
                    cur_len_d    = run_len;
                    best_start_d = win_start;
                    best_len_d   = win_len;
                    cnt_d        = '0;
                    delay_load_d = 1'b1;
                    if (last_tap) begin
                        centre_d    = centre_calc;
                        lane_fail_d = (win_len < LEN_W'(MIN_EYE));
                        delay_reg_d = centre_calc;
                        state_d     = ST_APPLY;
                    end else begin
                        tap_d       = tap_q + TAP_BITS'(1);
                        delay_reg_d = tap_q + TAP_BITS'(1);
                        state_d     = ST_SET_TAP;
                    end
                end
                ST_APPLY_SETTLE: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(SETTLE - 1)) begin
                        cnt_d = '0;
                        lane_tap_d[lane_q*TAP_BITS +: TAP_BITS] = centre_q;
                        fail_d[lane_q] = lane_fail_q;
                        if (lane_q == LAST_LANE) begin
                            state_d        = ST_DONE;
                            busy_d         = 1'b0;
                            done_d         = 1'b1;
                            delay_select_d = '0;
                        end else begin
                            lane_d  = lane_q + LANE_W'(1);
                            state_d = ST_WAIT_RDY;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q        <= ST_IDLE;
            lane_q         <= '0;
            tap_q          <= '0;
            cnt_q          <= '0;
            bad_q          <= 1'b0;
            cur_start_q    <= '0;
            cur_len_q      <= '0;
            best_start_q   <= '0;
            best_len_q     <= '0;
            centre_q       <= '0;
            lane_fail_q    <= 1'b0;
            delay_reg_q    <= '0;
            delay_select_q <= '0;
            delay_load_q   <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            fail_q         <= '0;
            lane_tap_q     <= '0;
        end else begin
            state_q        <= state_d;
            lane_q         <= lane_d;
            tap_q          <= tap_d;
            cnt_q          <= cnt_d;
            bad_q          <= bad_d;
            cur_start_q    <= cur_start_d;
            cur_len_q      <= cur_len_d;
            best_start_q   <= best_start_d;
            best_len_q     <= best_len_d;
            centre_q       <= centre_d;
            lane_fail_q    <= lane_fail_d;
            delay_reg_q    <= delay_reg_d;
            delay_select_q <= delay_select_d;
            delay_load_q   <= delay_load_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            fail_q         <= fail_d;
            lane_tap_q     <= lane_tap_d;
        end
    end

    assign delay_reg_o    = delay_reg_q;
    assign delay_select_o = delay_select_q;
    assign delay_load_o   = delay_load_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign fail_o         = fail_q;
    assign lane_tap_o     = lane_tap_q;
endmodule
